// File: rtl/bus_pkg.sv
// Shared encodings and default sizes for the B/C bus transfer datapath.
// Imported by the interface, the unary ALU and the transfer master.
package bus_pkg;

    localparam int WORD_WIDTH_DEFAULT = 8;
    localparam int NUM_REGS_DEFAULT   = 8;
    localparam int SEL_WIDTH_DEFAULT  = 3;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_NEG  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READ    = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_WRITE   = 2'b11
    } state_e;

endpackage

// File: rtl/bus_transfer_master_if.sv
// Sequencer handshake plus B/C bus signals of the transfer master.
// Optional BUS_FLOAT_CHECK_EN adds the bus_float_err pulse.
interface bus_transfer_master_if
    import bus_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int SEL_WIDTH  = SEL_WIDTH_DEFAULT
);

    logic                  start;
    logic [SEL_WIDTH-1:0]  src_sel;
    logic [SEL_WIDTH-1:0]  dst_sel;
    logic [1:0]            op;
    logic [WORD_WIDTH-1:0] b_bus;
    logic [NUM_REGS-1:0]   b_read_enable;
    logic [WORD_WIDTH-1:0] c_bus;
    logic [NUM_REGS-1:0]   c_write_enable;
    logic                  busy;
    logic                  done;
    logic                  sel_error;
    logic [WORD_WIDTH-1:0] result;
`ifdef BUS_FLOAT_CHECK_EN
    logic                  bus_float_err;
`endif

    modport master (
        input  start,
        input  src_sel,
        input  dst_sel,
        input  op,
        input  b_bus,
        output b_read_enable,
        output c_bus,
        output c_write_enable,
        output busy,
        output done,
        output sel_error,
`ifdef BUS_FLOAT_CHECK_EN
        output bus_float_err,
`endif
        output result
    );

    modport slave (
        output start,
        output src_sel,
        output dst_sel,
        output op,
        output b_bus,
        input  b_read_enable,
        input  c_bus,
        input  c_write_enable,
        input  busy,
        input  done,
        input  sel_error,
`ifdef BUS_FLOAT_CHECK_EN
        input  bus_float_err,
`endif
        input  result
    );

endinterface

// File: rtl/bus_unary_alu.sv
// Combinational unary op on one word: pass, inc, dec, negate.
// All results wrap modulo 2**WORD_WIDTH.
module bus_unary_alu
    import bus_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
    input  op_e                   op,
    input  logic [WORD_WIDTH-1:0] data,
    output logic [WORD_WIDTH-1:0] y
);

    always_comb begin
        y = data;
        unique case (op)
            OP_PASS: y = data;
            OP_INC:  y = data + WORD_WIDTH'(1);
            OP_DEC:  y = data - WORD_WIDTH'(1);
            OP_NEG:  y = WORD_WIDTH'(0) - data;
        endcase
    end

endmodule

// File: rtl/bus_transfer_master.sv
// Reads one register over B, applies a unary op, writes back over C.
// Define BUS_FLOAT_CHECK_EN to suppress writes of a floating B bus.
module bus_transfer_master
    import bus_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int SEL_WIDTH  = SEL_WIDTH_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    bus_transfer_master_if.master bus
);

    localparam logic [SEL_WIDTH:0] REG_LIMIT =
        (SEL_WIDTH+1)'(NUM_REGS);

    state_e                state;
    logic [SEL_WIDTH-1:0]  dst_q;
    op_e                   op_q;
    logic [WORD_WIDTH-1:0] alu_y;
    logic                  sel_ok;

    assign sel_ok = ({1'b0, bus.src_sel} < REG_LIMIT)
                 && ({1'b0, bus.dst_sel} < REG_LIMIT);

    bus_unary_alu #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_alu (
        .op  (op_q),
        .data(bus.b_bus),
        .y   (alu_y)
    );

`ifdef BUS_FLOAT_CHECK_EN
    logic float_q;
    logic bus_unknown;

    // True only in simulation when some B bus bit is X or Z.
    assign bus_unknown = ((^bus.b_bus) === 1'bx);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            dst_q              <= '0;
            op_q               <= OP_PASS;
            bus.b_read_enable  <= '0;
            bus.c_bus          <= '0;
            bus.c_write_enable <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.sel_error      <= 1'b0;
            bus.result         <= '0;
`ifdef BUS_FLOAT_CHECK_EN
            float_q            <= 1'b0;
            bus.bus_float_err  <= 1'b0;
`endif
        end else begin
            bus.sel_error <= 1'b0;
            bus.done      <= 1'b0;
`ifdef BUS_FLOAT_CHECK_EN
            bus.bus_float_err <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (sel_ok) begin
                            dst_q <= bus.dst_sel;
                            op_q  <= op_e'(bus.op);
                            bus.b_read_enable <=
                                NUM_REGS'(1) << bus.src_sel;
                            bus.busy <= 1'b1;
                            state    <= ST_READ;
                        end else begin
                            bus.sel_error <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    bus.b_read_enable <= '0;
                    state             <= ST_CAPTURE;
`ifdef BUS_FLOAT_CHECK_EN
                    float_q <= bus_unknown;
                    if (!bus_unknown) begin
                        bus.c_bus  <= alu_y;
                        bus.result <= alu_y;
                        bus.c_write_enable <=
                            NUM_REGS'(1) << dst_q;
                    end
`else
                    bus.c_bus  <= alu_y;
                    bus.result <= alu_y;
                    bus.c_write_enable <=
                        NUM_REGS'(1) << dst_q;
`endif
                end
                ST_CAPTURE: begin
                    bus.c_write_enable <= '0;
                    bus.done           <= 1'b1;
                    bus.busy           <= 1'b0;
                    state              <= ST_WRITE;
`ifdef BUS_FLOAT_CHECK_EN
                    bus.bus_float_err <= float_q;
`endif
                end
                ST_WRITE: begin
                    // Start is deliberately not sampled here.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_master.sv
// Directed bench for bus_transfer_master with a timeline model.
// Covers BUS_FLOAT_CHECK_EN when that macro is defined.
module tb_bus_transfer_master;

    localparam int W  = 8;
    localparam int NR = 6;
    localparam int SW = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bus_transfer_master_if #(
        .WORD_WIDTH(W), .NUM_REGS(NR), .SEL_WIDTH(SW)
    ) bus_i ();

    bus_transfer_master #(
        .WORD_WIDTH(W), .NUM_REGS(NR), .SEL_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment and presets
    logic [W-1:0] regs [NR];
    logic [W-1:0] mregs [NR];
    logic         pre_en;
    int           pre_idx;
    logic [W-1:0] pre_val;
    logic         float_mode;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] f(input int o,
                                        input logic [W-1:0] d);
        int v;
        int r;
        v = int'(d);
        if (o == 0) r = v;
        else if (o == 1) r = v + 1;
        else if (o == 2) r = v - 1;
        else r = 256 - v;
        return W'(r);
    endfunction

    always @(posedge clk) begin
        if (pre_en) regs[pre_idx] = pre_val;
        else if (!rst) begin
            for (int i = 0; i < NR; i++)
                if (bus_i.c_write_enable[i])
                    regs[i] = bus_i.c_bus;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] v;
        logic hit;
        v = '0;
        hit = 1'b0;
        for (int i = 0; i < NR; i++)
            if (bus_i.b_read_enable[i]) begin
                v = regs[i];
                hit = 1'b1;
            end
        if (hit && !float_mode) bus_i.b_bus = v;
`ifdef BUS_FLOAT_CHECK_EN
        else bus_i.b_bus = 'z;
`else
        else bus_i.b_bus = '0;
`endif
    end

    // Timeline model: outputs as a function of edges since accept
    int           cyc = 0;
    int           t_acc = -100;
    int           next_ok = 0;
    int           p_src, p_dst, p_op;
    logic         p_float;
    logic [NR-1:0] e_bre, e_cwe;
    logic [W-1:0] e_cbus, e_result;
    logic         e_busy, e_done, e_selerr, e_ferr;

    initial begin
        e_bre = '0; e_cwe = '0; e_cbus = '0; e_result = '0;
        e_busy = 0; e_done = 0; e_selerr = 0; e_ferr = 0;
        p_float = 0; p_src = 0; p_dst = 0; p_op = 0;
    end

    always @(posedge clk) begin
        int age;
        cyc++;
        e_selerr = 0;
        e_done = 0;
        e_ferr = 0;
        if (pre_en) mregs[pre_idx] = pre_val;
        if (rst) begin
            e_bre = '0; e_cwe = '0; e_cbus = '0;
            e_result = '0; e_busy = 0;
            t_acc = -100;
            next_ok = cyc + 1;
        end else begin
            age = cyc - t_acc;
            if (age == 1) begin
                e_bre = '0;
                if (!p_float) begin
                    e_cbus = f(p_op, mregs[p_src]);
                    e_result = e_cbus;
                    e_cwe = NR'(1) << p_dst;
                end
            end else if (age == 2) begin
                e_cwe = '0;
                if (!p_float) mregs[p_dst] = e_cbus;
                e_done = 1;
                e_busy = 0;
                e_ferr = p_float;
            end else if (cyc >= next_ok && bus_i.start) begin
                if (int'(bus_i.src_sel) < NR &&
                    int'(bus_i.dst_sel) < NR) begin
                    t_acc = cyc;
                    next_ok = cyc + 4;
                    p_src = int'(bus_i.src_sel);
                    p_dst = int'(bus_i.dst_sel);
                    p_op = int'(bus_i.op);
                    p_float = float_mode;
                    e_bre = NR'(1) << p_src;
                    e_busy = 1;
                end else begin
                    e_selerr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("b_read_enable", 32'(bus_i.b_read_enable), 32'(e_bre));
            chk("c_write_enable", 32'(bus_i.c_write_enable), 32'(e_cwe));
            chk("c_bus", 32'(bus_i.c_bus), 32'(e_cbus));
            chk("result", 32'(bus_i.result), 32'(e_result));
            chk("busy", 32'(bus_i.busy), 32'(e_busy));
            chk("done", 32'(bus_i.done), 32'(e_done));
            chk("sel_error", 32'(bus_i.sel_error), 32'(e_selerr));
`ifdef BUS_FLOAT_CHECK_EN
            chk("bus_float_err", 32'(bus_i.bus_float_err), 32'(e_ferr));
`endif
            chk("enable_overlap",
                32'(|(bus_i.b_read_enable & bus_i.c_write_enable)), 0);
            chk("bre_onehot",
                32'($countones(bus_i.b_read_enable) > 1), 0);
        end
    end

    task automatic preset(input int idx, input logic [W-1:0] val);
        @(negedge clk);
        pre_en = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic xfer(input int s, input int d, input int o);
        @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.src_sel = SW'(s);
        bus_i.dst_sel = SW'(d);
        bus_i.op = 2'(o);
        @(negedge clk);
        bus_i.start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        pre_en = 1'b0;
        pre_idx = 0;
        pre_val = '0;
        float_mode = 1'b0;
        bus_i.start = 1'b0;
        bus_i.src_sel = '0;
        bus_i.dst_sel = '0;
        bus_i.op = '0;
        bus_i.b_bus = '0;
        for (int i = 0; i < NR; i++) begin
            regs[i] = '0;
            mregs[i] = '0;
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus_i.busy), 0);
        chk("rst_c_bus", 32'(bus_i.c_bus), 0);
        chk("rst_enables",
            32'({bus_i.b_read_enable, bus_i.c_write_enable}), 0);
        rst = 1'b0;

        // reg2=0x3C, inc into reg5
        preset(2, 8'h3C);
        @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.src_sel = 3'd2;
        bus_i.dst_sel = 3'd5;
        bus_i.op = 2'b01;
        @(negedge clk);
        bus_i.start = 1'b0;
        chk("t1_bre", 32'(bus_i.b_read_enable), 32'h04);
        chk("t1_busy", 32'(bus_i.busy), 1);
        @(negedge clk);
        chk("t1_cwe", 32'(bus_i.c_write_enable), 32'h20);
        chk("t1_cbus", 32'(bus_i.c_bus), 32'h3D);
        @(negedge clk);
        chk("t1_done", 32'(bus_i.done), 1);
        chk("t1_busy_low", 32'(bus_i.busy), 0);
        @(negedge clk);
        chk("t1_done_low", 32'(bus_i.done), 0);
        chk("t1_reg5", 32'(regs[5]), 32'h3D);
        chk("t1_model_reg5", 32'(mregs[5]), 32'h3D);

        // read-modify-write on reg0 with wrap cases
        preset(0, 8'hFF);
        xfer(0, 0, 1);
        chk("inc_wrap", 32'(regs[0]), 32'h00);
        xfer(0, 0, 2);
        chk("dec_wrap", 32'(regs[0]), 32'hFF);
        preset(0, 8'h80);
        xfer(0, 0, 3);
        chk("neg_80", 32'(regs[0]), 32'h80);
        preset(0, 8'h01);
        xfer(0, 0, 3);
        chk("neg_01", 32'(regs[0]), 32'hFF);
        chk("neg_01_result", 32'(bus_i.result), 32'hFF);

        // rejected selects
        @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.src_sel = 3'd7;
        bus_i.dst_sel = 3'd0;
        @(negedge clk);
        bus_i.start = 1'b0;
        chk("sel7_err", 32'(bus_i.sel_error), 1);
        chk("sel7_bre", 32'(bus_i.b_read_enable), 0);
        chk("sel7_busy", 32'(bus_i.busy), 0);
        @(negedge clk);
        chk("sel7_err_low", 32'(bus_i.sel_error), 0);
        bus_i.start = 1'b1;
        bus_i.src_sel = 3'd0;
        bus_i.dst_sel = 3'd6;
        @(negedge clk);
        bus_i.start = 1'b0;
        chk("dst6_err", 32'(bus_i.sel_error), 1);
        chk("dst6_bre", 32'(bus_i.b_read_enable), 0);
        repeat (2) @(negedge clk);

        // start held high: one accept every 4 cycles
        preset(1, 8'h10);
        @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.src_sel = 3'd1;
        bus_i.dst_sel = 3'd1;
        bus_i.op = 2'b01;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_i.done) n++;
        end
        bus_i.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_i.done) n++;
        end
        chk("hold_dones", 32'(n), 3);
        chk("hold_reg1", 32'(regs[1]), 32'h13);

`ifdef BUS_FLOAT_CHECK_EN
        // floating source: no write, result held
        preset(3, 8'h77);
        float_mode = 1'b1;
        xfer(2, 3, 0);
        float_mode = 1'b0;
        chk("float_reg3", 32'(regs[3]), 32'h77);
        chk("float_result", 32'(bus_i.result), 32'h13);
`endif

        // reset during CAPTURE
        preset(3, 8'h11);
        preset(4, 8'h55);
        @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.src_sel = 3'd3;
        bus_i.dst_sel = 3'd4;
        bus_i.op = 2'b00;
        @(negedge clk);
        bus_i.start = 1'b0;
        @(negedge clk);
        chk("rc_cwe", 32'(bus_i.c_write_enable), 32'h10);
        chk("rc_cbus", 32'(bus_i.c_bus), 32'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rc_cwe_low", 32'(bus_i.c_write_enable), 0);
        chk("rc_cbus_zero", 32'(bus_i.c_bus), 0);
        chk("rc_done", 32'(bus_i.done), 0);
        chk("rc_result", 32'(bus_i.result), 0);
        @(negedge clk);
        chk("rc_done_after", 32'(bus_i.done), 0);
        chk("rc_reg4", 32'(regs[4]), 32'h55);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_transfer_master.md
Name: bus_transfer_master

Overview:
- Datapath-side master for the B/C bus pair used by the IJVM register file (TOS, SP, LV, and the rest).
- Selects one source register onto the B bus and captures its value, then applies a unary op.
- Writes the result back through the C bus into one destination register.
- Sequenced by a start/busy/done handshake from the microsequencer.

Parameters:
WORD_WIDTH, 8, width of B bus, C bus and result
NUM_REGS, 8, number of bus-attached registers; width of the one-hot enable vectors
SEL_WIDTH, 3, width of src_sel/dst_sel; must satisfy 2**SEL_WIDTH >= NUM_REGS

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only in IDLE
src_sel  input  SEL_WIDTH  index of the register read over the B bus
dst_sel  input  SEL_WIDTH  index of the register written over the C bus
op  input  2  00 pass, 01 increment, 10 decrement, 11 two's-complement negate
b_bus  input  WORD_WIDTH  shared B bus; registers drive it on negedge while enabled, otherwise it floats
b_read_enable  output  NUM_REGS  one-hot source enable, registered
c_bus  output  WORD_WIDTH  write-back data, registered
c_write_enable  output  NUM_REGS  one-hot destination enable, registered
busy  output  1  high from the accept edge until done
done  output  1  one-cycle completion pulse
sel_error  output  1  one-cycle pulse on a rejected request
result  output  WORD_WIDTH  last written value, held until the next transfer

Behaviour:
- Reset (synchronous, dominates all else): state IDLE; every output is 0, including c_bus; latched sel/op cleared.
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE + start, src_sel<NUM_REGS, dst_sel<NUM_REGS: latch sels and op; b_read_enable[src_sel]=1; busy=1; go to READ.
- IDLE + start with either sel >= NUM_REGS: stay IDLE; sel_error=1 for one cycle; no enable asserted.
- READ (1 cycle): the source drives b_bus at the mid-cycle negedge.
  - Next posedge: capture b_bus, compute f(op) modulo 2**WORD_WIDTH.
  - Load the computed value into c_bus and result.
  - b_read_enable=0; c_write_enable[dst]=1; go to CAPTURE.
- CAPTURE (1 cycle): c_bus stable with the destination enable high; the destination latches at the following posedge.
  - Next posedge: c_write_enable=0; go to WRITE.
- WRITE (1 cycle): done=1, busy=0.
  - Next posedge: done=0; go to IDLE.
  - A start at this edge is not accepted; the earliest accept is the following edge.
- Latency: accept edge to done-high is 3 clk edges. Back-to-back issue interval is 4 cycles minimum.
- Arithmetic wraps: inc 0xFF->0x00, dec 0x00->0xFF, neg 0x80->0x80 (W=8).
- src==dst is legal (read-modify-write of one register, e.g. TOS increment).
- At most one bit of b_read_enable and one bit of c_write_enable is ever high. Both are never high in the same cycle.
- start while busy is ignored without error. Inputs are not re-sampled mid-transfer.
- rst asserted in any state: at that posedge all enables drop, c_bus=0, state IDLE. No partial write completes after the reset edge.
- c_bus holds its last value after WRITE. It is cleared only by reset.

Optional Feature:
- Macro: BUS_FLOAT_CHECK_EN.
- Defined: at the READ->CAPTURE edge, if captured b_bus contains any X/Z bit (simulation case-equality check):
  - the write is suppressed: c_write_enable stays 0, result unchanged;
  - done still pulses;
  - port bus_float_err pulses 1 cycle alongside done.
- Undefined: the bus_float_err port and the check are absent. The captured value is used as-is.

Decomposition:
- Shared package bus_pkg:
  - op encodings OP_PASS/OP_INC/OP_DEC/OP_NEG;
  - FSM state encoding;
  - default WORD_WIDTH/NUM_REGS constants.
- Natural sub-module: bus_unary_alu. Combinational f(op, data), WORD_WIDTH parameter, reused by later datapath blocks.
- One-hot decode is kept inline.

Test Plan:
- Reg model 2 holds 0x3C; start src=2 dst=5 op=01 -> b_read_enable=0x04 one cycle; then c_write_enable=0x20 with c_bus=0x3D one cycle; done on 3rd edge; model reg5=0x3D.
- Src=dst=0 holding 0xFF, op=01 -> reg0=0x00; op=10 on 0x00 -> 0xFF; op=11 on 0x80 -> 0x80; op=11 on 0x01 -> 0xFF.
- start with src_sel=7, NUM_REGS=6 -> sel_error pulse; both enable vectors stay 0; busy stays 0.
- start held high continuously -> transfers accepted every 4 cycles only; enables never overlap; single done per transfer.
- rst asserted during CAPTURE -> c_write_enable=0 and c_bus=0 at that edge; destination unchanged; no done pulse.
- BUS_FLOAT_CHECK_EN defined, source model not driving (Z) -> bus_float_err=1 with done; no c_write_enable pulse; result retains prior value.
